z80_nmi_seq: RTL and testbench

Z80_NMI_SEQ -- requirements
Module: z80_nmi_seq

---
 rtl/z80_nmi_seq.sv | 159 +++++++++++++++
 tb/tb_z80_nmi_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/z80_nmi_seq.sv
// Z80 non-maskable interrupt sequencer: edge-detects /NMI, then runs ACK, two stack pushes and PC/SP/IFF write-back.
// Optional build macro Z80_NMI_SYNC_EN inserts a two-flop synchronizer on nmi_n ahead of the edge detector.
module z80_nmi_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nmi_n,
  input  logic        insn_done,
  input  logic        halted,
  input  logic [15:0] pc_in,
  input  logic [15:0] sp_in,
  input  logic        iff1_in,
  output logic        mem_wr,
  output logic [15:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_wr_done,
  output logic        nmi_ack,
  output logic        busy,
  output logic [15:0] pc_out,
  output logic [15:0] sp_out,
  output logic        pc_we,
  output logic        sp_we,
  output logic        iff1_out,
  output logic        iff2_out,
  output logic        iff_we
);

  typedef enum logic [2:0] {IDLE, ACK, PUSH_HI, PUSH_LO, LOAD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] sp_q, sp_d;
  logic        iff1_q, iff1_d;
  logic        nmi_s;
  logic        fall;
  logic        accept;
  logic [15:0] sp_m1;
  logic [15:0] sp_m2;

`ifdef Z80_NMI_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= nmi_n;
      sync2_q <= sync1_q;
    end
  end

  assign nmi_s = sync2_q;
`else
  assign nmi_s = nmi_n;
`endif

  // History resets high so a pin already low at reset release is not seen as an edge.
  assign fall       = nmi_prev_q & ~nmi_s;
  assign nmi_prev_d = nmi_s;
  assign sp_m1      = sp_q - 16'd1;
  assign sp_m2      = sp_q - 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pending_q  <= 1'b0;
      nmi_prev_q <= 1'b1;
      pc_q       <= 16'd0;
      sp_q       <= 16'd0;
      iff1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      nmi_prev_q <= nmi_prev_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      iff1_q     <= iff1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    iff1_d    = iff1_q;
    accept    = 1'b0;
    mem_wr    = 1'b0;
    mem_waddr = 16'd0;
    mem_wdata = 8'd0;
    nmi_ack   = 1'b0;
    busy      = 1'b0;
    pc_out    = 16'd0;
    sp_out    = 16'd0;
    pc_we     = 1'b0;
    sp_we     = 1'b0;
    iff1_out  = 1'b0;
    iff2_out  = 1'b0;
    iff_we    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (pending_q && (insn_done || halted)) begin
          accept  = 1'b1;
          state_d = ACK;
          pc_d    = pc_in;
          sp_d    = sp_in;
          iff1_d  = iff1_in;
        end
      end
      ACK: begin
        nmi_ack = 1'b1;
        busy    = 1'b1;
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
          state_d = PUSH_HI;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      PUSH_HI: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_waddr = sp_m1;
        mem_wdata = pc_q[15:8];
        if (mem_wr_done) state_d = PUSH_LO;
      end
      PUSH_LO: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_waddr = sp_m2;
        mem_wdata = pc_q[7:0];
        if (mem_wr_done) state_d = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        pc_out   = 16'h0066;
        sp_out   = sp_m2;
        iff1_out = 1'b0;
        iff2_out = iff1_q;
        pc_we    = 1'b1;
        sp_we    = 1'b1;
        iff_we   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An edge arriving in the acceptance cycle is a new request and must survive the clear.
    pending_d = (pending_q & ~accept) | fall;
  end

endmodule

// File: tb/tb_z80_nmi_seq.sv
// Self-checking bench for z80_nmi_seq: directed and randomized NMI sequences checked against a transaction-level model.
// Honours Z80_NMI_SYNC_EN for the expected edge-to-pending latency.
module tb_z80_nmi_seq;

`ifdef Z80_NMI_SYNC_EN
  localparam int EDGE_LAT = 3;
`else
  localparam int EDGE_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        nmi_n;
  logic        insn_done;
  logic        halted;
  logic [15:0] pc_in;
  logic [15:0] sp_in;
  logic        iff1_in;
  logic        mem_wr;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_wr_done;
  logic        nmi_ack;
  logic        busy;
  logic [15:0] pc_out;
  logic [15:0] sp_out;
  logic        pc_we;
  logic        sp_we;
  logic        iff1_out;
  logic        iff2_out;
  logic        iff_we;

  int total = 0;
  int bad   = 0;

  z80_nmi_seq dut (
    .clk(clk), .reset_n(reset_n), .nmi_n(nmi_n), .insn_done(insn_done), .halted(halted),
    .pc_in(pc_in), .sp_in(sp_in), .iff1_in(iff1_in),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr_done(mem_wr_done),
    .nmi_ack(nmi_ack), .busy(busy), .pc_out(pc_out), .sp_out(sp_out),
    .pc_we(pc_we), .sp_we(sp_we), .iff1_out(iff1_out), .iff2_out(iff2_out), .iff_we(iff_we)
  );

  always #5 clk = ~clk;

  wire [63:0] allOut = {mem_wr, mem_waddr, mem_wdata, nmi_ack, busy, pc_out, sp_out,
                        pc_we, sp_we, iff1_out, iff2_out, iff_we};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quiet cycles with nmi_n released so the next edge is seen cleanly.
  task automatic idleCycles(input int n);
    nmi_n       = 1'b1;
    insn_done   = 1'b0;
    halted      = 1'b0;
    mem_wr_done = 1'b0;
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // One NMI transaction, entered and left on a negedge. Expected values come from the
  // architectural rules: start after edge latency plus boundary, 5 ack cycles,
  // two pushes of PC at SP-1/SP-2 each lasting (delay+1) cycles, then one write-back cycle.
  task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] sp, input logic iff1,
                               input bit newEdge, input bit useHalt, input int strobeDly,
                               input int d1, input int d2, input bit edgeInPush, input bit abortInLo);
    int          lat, expStart, c, n;
    bit          ok;
    logic [15:0] addrHi, addrLo;
    pc_in   = pc;
    sp_in   = sp;
    iff1_in = iff1;
    halted  = useHalt;
    lat     = newEdge ? EDGE_LAT : 0;
    if (newEdge) nmi_n = 1'b0;
    expStart = useHalt ? lat + 1 : lat + strobeDly + 1;
    addrHi   = 16'(sp - 16'd1);
    addrLo   = 16'(sp - 16'd2);

    c = 0;
    while (!busy && c < 60) begin
      insn_done = (!useHalt && c == lat + strobeDly);
      @(negedge clk);
      c++;
    end
    insn_done = 1'b0;
    halted    = 1'b0;
    checkOutput("start_cycle", 64'(c), 64'(expStart));

    // Scramble live inputs: the sequence must use the values captured at acceptance.
    pc_in   = ~pc;
    sp_in   = ~sp;
    iff1_in = ~iff1;

    ok = 1'b1;
    n  = 0;
    while (nmi_ack && n < 20) begin
      ok &= (mem_wr === 1'b0) && (busy === 1'b1);
      mem_wr_done = 1'($urandom);
      if (edgeInPush && n == 1) nmi_n = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("ack_len", 64'(n), 64'd5);
    checkOutput("ack_quiet", 64'(ok), 64'd1);

    if (edgeInPush) nmi_n = 1'b0;
    ok = 1'b1;
    for (int j = 0; j <= d1; j++) begin
      ok &= (mem_wr === 1'b1) && (mem_waddr === addrHi) && (mem_wdata === pc[15:8]) && (busy === 1'b1);
      mem_wr_done = (j == d1);
      @(negedge clk);
    end
    checkOutput("push_hi", 64'(ok), 64'd1);

    ok = 1'b1;
    for (int j = 0; j <= d2; j++) begin
      ok &= (mem_wr === 1'b1) && (mem_waddr === addrLo) && (mem_wdata === pc[7:0]) && (busy === 1'b1);
      if (abortInLo && j == 0) begin
        mem_wr_done = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("pre_abort_push_lo", 64'(ok), 64'd1);
        checkOutput("abort_outputs", allOut, 64'd0);
        return;
      end
      mem_wr_done = (j == d2);
      @(negedge clk);
    end
    mem_wr_done = 1'b0;
    checkOutput("push_lo", 64'(ok), 64'd1);

    checkOutput("load", 64'({pc_out, sp_out, iff1_out, iff2_out, pc_we, sp_we, iff_we, busy, mem_wr}),
                64'({16'h0066, addrLo, 1'b0, iff1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    checkOutput("back_idle", 64'({busy, pc_we, sp_we, iff_we, mem_wr, nmi_ack}), 64'd0);
  endtask

  initial begin
    bit saw;
    reset_n     = 1'b0;
    nmi_n       = 1'b1;
    insn_done   = 1'b0;
    halted      = 1'b0;
    pc_in       = 16'd0;
    sp_in       = 16'd0;
    iff1_in     = 1'b0;
    mem_wr_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOut, 64'd0);
    reset_n = 1'b1;

    // No sequence without an edge, even with boundaries and stray write acks.
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      insn_done   = 1'b1;
      mem_wr_done = 1'b1;
      @(negedge clk);
      saw |= busy;
    end
    checkOutput("no_false_start", 64'(saw), 64'd0);
    idleCycles(4);

    $display("[TB] basic sequence");
    applyStimulus(16'h1234, 16'h8000, 1'b1, 1, 0, 0, 0, 0, 0, 0);
    idleCycles(4);

    $display("[TB] sp wrap with slow memory");
    applyStimulus(16'($urandom), 16'h0000, 1'($urandom), 1, 0, 2, 3, 3, 0, 0);
    idleCycles(4);

    $display("[TB] halted boundary");
    applyStimulus(16'hBEEF, 16'h4000, 1'b0, 1, 1, 0, 1, 0, 0, 0);
    idleCycles(4);

    $display("[TB] held-low nmi and second edge in push");
    applyStimulus(16'h0F0F, 16'h2000, 1'b1, 1, 0, 1, 0, 0, 0, 0);
    saw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      insn_done = (k % 4 == 0);
      @(negedge clk);
      saw |= busy;
    end
    insn_done = 1'b0;
    checkOutput("held_low_single", 64'(saw), 64'd0);
    idleCycles(4);
    applyStimulus(16'hA55A, 16'h1001, 1'b1, 1, 0, 0, 2, 1, 1, 0);
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      saw |= busy;
    end
    checkOutput("second_waits_boundary", 64'(saw), 64'd0);
    applyStimulus(16'h5AA5, 16'h3003, 1'b0, 0, 0, 2, 0, 0, 0, 0);
    idleCycles(4);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1, 1'($urandom),
                    int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)), 0, 0);
      idleCycles(4);
    end

    $display("[TB] reset abort in push_lo");
    applyStimulus(16'hC0DE, 16'h9000, 1'b1, 1, 0, 0, 1, 2, 0, 1);
    nmi_n = 1'b1;
    @(negedge clk);
    saw = 1'b0;
    saw |= pc_we | sp_we | iff_we | mem_wr | busy;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      halted = 1'b1;
      @(negedge clk);
      saw |= busy | pc_we | sp_we | iff_we;
    end
    halted = 1'b0;
    checkOutput("abort_clears_pending", 64'(saw), 64'd0);
    idleCycles(4);
    applyStimulus(16'h7777, 16'h0001, 1'b1, 1, 0, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
